frame_commit_ctrl: RTL and testbench

FRAME_COMMIT_CTRL -- requirements
Module: frame_commit_ctrl

---
 rtl/frame_commit_pkg.sv | 33 +++
 rtl/frame_commit_regfile.sv | 45 ++++
 rtl/frame_commit_ctrl.sv | 122 ++++++++++++
 tb/tb_frame_commit_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_commit_pkg.sv
// Shared types and constants for the vblank-synchronised frame commit controller.
package frame_commit_pkg;

  localparam int DEFAULT_NUM_REGS = 16;

  localparam logic [4:0] ADDR_CTRL = 5'd16;
  localparam logic [4:0] ADDR_STAT = 5'd17;

  localparam int CTRL_ARM_BIT     = 0;
  localparam int CTRL_CANCEL_BIT  = 1;
  localparam int CTRL_IRQ_CLR_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COPY,
    ST_DONE
  } state_t;

  localparam logic [7:0] RESET_BYTES [16] = '{
    8'h00, 8'h32, 8'h01, 8'h2C, 8'h02, 8'h58, 8'h0A, 8'h0F,
    8'h14, 8'h08, 8'h88, 8'h05, 8'h00, 8'hC8, 8'h00, 8'h00
  };

  // Registers beyond the table start at zero when NUM_REGS is enlarged.
  function automatic logic [7:0] reset_byte(input int idx);
    logic [3:0] short_idx;
    short_idx = idx[3:0];
    if (idx < 16) return RESET_BYTES[short_idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/frame_commit_regfile.sv
// Shadow (CPU-written) and active (renderer-visible) byte banks with a one-byte-per-cycle copy port.
module frame_commit_regfile
  import frame_commit_pkg::*;
#(
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_data,
  input  logic                  copy_en,
  input  logic [IDX_W-1:0]      copy_idx,
  output logic [8*NUM_REGS-1:0] active_flat
);

  logic [7:0] shadow [NUM_REGS];
  logic [7:0] active [NUM_REGS];

  // NOTE: both banks are reset explicitly because the renderer needs a valid
  // initial frame; this keeps them as flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) shadow[k] <= reset_byte(k);
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  // NOTE: non-blocking assignment means a same-cycle shadow write to the byte
  // being copied is not seen here; the pre-write value is committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) active[k] <= reset_byte(k);
    end else if (copy_en) begin
      active[copy_idx] <= shadow[copy_idx];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign active_flat[8*g +: 8] = active[g];
  end

endmodule

// File: rtl/frame_commit_ctrl.sv
// Avalon-MM slave that commits shadow game registers to the renderer on a vblank rising edge.
// Optional macro COMMIT_IRQ_EN enables the commit interrupt (irq tied low otherwise).
module frame_commit_ctrl
  import frame_commit_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [4:0]            address,
  input  logic [7:0]            writedata,
  output logic [7:0]            readdata,
  input  logic                  vblank,
  output logic [8*NUM_REGS-1:0] active_regs,
  output logic                  busy,
  output logic                  commit_done,
  output logic                  irq
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t           state, state_nxt;
  logic             pending, pending_nxt;
  logic             vblank_q;
  logic [IDX_W-1:0] copy_idx;
  logic [4:0]       frame_count;
  logic             irq_q;

  logic bus_wr, ctrl_wr, shadow_wr, arm_req, cancel_req;
  logic vblank_rise, copy_start, last_copy;

  assign bus_wr      = chipselect & write;
  assign ctrl_wr     = bus_wr & (address == ADDR_CTRL);
  assign shadow_wr   = bus_wr & (int'(address) < NUM_REGS);
  assign arm_req     = ctrl_wr & writedata[CTRL_ARM_BIT];
  assign cancel_req  = ctrl_wr & writedata[CTRL_CANCEL_BIT];
  assign vblank_rise = vblank & ~vblank_q;
  assign copy_start  = (state == ST_ARMED) & pending & vblank_rise;
  assign last_copy   = (copy_idx == IDX_W'(NUM_REGS - 1));

  // Cancel has the last word so a simultaneous arm+cancel leaves nothing pending.
  always_comb begin
    pending_nxt = pending;
    if (copy_start) pending_nxt = 1'b0;
    if (arm_req)    pending_nxt = 1'b1;
    if (cancel_req) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pending) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!pending)        state_nxt = ST_IDLE;
        else if (vblank_rise) state_nxt = ST_COPY;
      end
      ST_COPY:  if (last_copy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = pending_nxt ? ST_ARMED : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == ST_COPY);
    commit_done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q    <= 1'b0;
      pending     <= 1'b0;
      copy_idx    <= '0;
      frame_count <= '0;
      readdata    <= 8'h00;
    end else begin
      vblank_q <= vblank;
      pending  <= pending_nxt;
      if (state == ST_COPY && !last_copy) copy_idx <= copy_idx + 1'b1;
      else                                copy_idx <= '0;
      if (state == ST_DONE) frame_count <= frame_count + 1'b1;
      if (chipselect && read && address == ADDR_STAT)
        readdata <= {busy, pending, irq_q, frame_count};
      else
        readdata <= 8'h00;
    end
  end

`ifdef COMMIT_IRQ_EN
  // A commit finishing in the same cycle as a clear keeps the interrupt raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      irq_q <= 1'b0;
    else if (state == ST_DONE)                      irq_q <= 1'b1;
    else if (ctrl_wr && writedata[CTRL_IRQ_CLR_BIT]) irq_q <= 1'b0;
  end
`else
  assign irq_q = 1'b0;
`endif

  assign irq = irq_q;

  frame_commit_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (shadow_wr),
    .wr_idx      (address[IDX_W-1:0]),
    .wr_data     (writedata),
    .copy_en     (busy),
    .copy_idx    (copy_idx),
    .active_flat (active_regs)
  );

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Self-checking bench for frame_commit_ctrl against a frame-level model of shadow/active banks.
module tb_frame_commit_ctrl;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           chipselect, write, read;
  logic [4:0]     address;
  logic [7:0]     writedata, readdata;
  logic           vblank;
  logic [8*N-1:0] active_regs;
  logic           busy, commit_done, irq;

  frame_commit_ctrl #(.NUM_REGS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .vblank      (vblank),
    .active_regs (active_regs),
    .busy        (busy),
    .commit_done (commit_done),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rst_tbl [N] = '{8'h00, 8'h32, 8'h01, 8'h2C, 8'h02, 8'h58, 8'h0A, 8'h0F,
                              8'h14, 8'h08, 8'h88, 8'h05, 8'h00, 8'hC8, 8'h00, 8'h00};
  logic [7:0] shadow_m [N];
  logic [7:0] active_m [N];
  int         commits_m;
  logic       pend_m, irq_m;

  function automatic logic [8*N-1:0] exp_active();
    logic [8*N-1:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = active_m[k];
    return v;
  endfunction

  function automatic logic [7:0] exp_status();
    logic [4:0] fc;
    fc = commits_m[4:0];
    return {1'b0, pend_m, irq_m, fc};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      shadow_m[k] = rst_tbl[k];
      active_m[k] = rst_tbl[k];
    end
    commits_m = 0; pend_m = 1'b0; irq_m = 1'b0;
  endtask

  task automatic model_commit();
    for (int k = 0; k < N; k++) active_m[k] = shadow_m[k];
    commits_m++;
`ifdef COMMIT_IRQ_EN
    irq_m = 1'b1;
`endif
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    if (a < 5'd16) shadow_m[a[3:0]] = d;
    if (a == 5'd16) begin
      if (d[0]) pend_m = 1'b1;
      if (d[1]) pend_m = 1'b0;
`ifdef COMMIT_IRQ_EN
      if (d[7]) irq_m = 1'b0;
`endif
    end
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  // Assumes a request is pending; produces a clean vblank pulse and follows the commit.
  task automatic do_commit(output int busy_cycles, output bit done_seen);
    tick(); tick();
    pend_m = 1'b0;
    vblank = 1'b1;
    busy_cycles = 0; done_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (commit_done) begin done_seen = 1'b1; break; end
    end
    model_commit();
    vblank = 1'b0;
    tick();
  endtask

  task automatic wait_busy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (commit_done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic count_busy(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) seen++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] st;
    n_checks++;
    if (active_regs[15:0] !== 16'h3200) begin
      n_fail++; $display("FAIL reset_bytes01: got %h expected 3200", active_regs[15:0]);
    end
    n_checks++;
    if (active_regs[87:80] !== 8'h88) begin
      n_fail++; $display("FAIL reset_byte10: got %h expected 88", active_regs[87:80]);
    end
    n_checks++;
    if (active_regs !== exp_active()) begin
      n_fail++; $display("FAIL reset_active: got %h expected %h", active_regs, exp_active());
    end
    n_checks++;
    if ({busy, commit_done, irq} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, commit_done, irq});
    end
    bus_read(5'd17, st);
    n_checks++;
    if (st !== 8'h00) begin
      n_fail++; $display("FAIL reset_status: got %h expected 00", st);
    end
  endtask

  task automatic test_commit();
    int bc; bit dn; logic [7:0] st;
    bus_write(5'd0, 8'h01);
    bus_write(5'd1, 8'hF4);
    bus_write(5'd16, 8'h01);
    do_commit(bc, dn);
    n_checks++;
    if (bc !== 16) begin
      n_fail++; $display("FAIL commit_busy_len: got %0d expected 16", bc);
    end
    n_checks++;
    if (!dn) begin
      n_fail++; $display("FAIL commit_done_pulse: got 0 expected 1");
    end
    n_checks++;
    if (active_regs[15:0] !== 16'hF401) begin
      n_fail++; $display("FAIL commit_bytes01: got %h expected f401", active_regs[15:0]);
    end
    bus_read(5'd17, st);
    n_checks++;
    if (st !== exp_status()) begin
      n_fail++; $display("FAIL commit_status: got %h expected %h", st, exp_status());
    end
  endtask

  task automatic test_no_edge();
    int nb, bc; bit dn; logic [7:0] st;
    vblank = 1'b1;
    tick(); tick();
    bus_write(5'd3, 8'($urandom));
    bus_write(5'd16, 8'h01);
    count_busy(20, nb);
    n_checks++;
    if (nb !== 0 || active_regs !== exp_active()) begin
      n_fail++; $display("FAIL noedge_hold: got busy=%0d active=%h expected busy=0 active=%h",
                         nb, active_regs, exp_active());
    end
    bus_read(5'd17, st);
    n_checks++;
    if (st !== exp_status()) begin
      n_fail++; $display("FAIL noedge_pending: got %h expected %h", st, exp_status());
    end
    vblank = 1'b0;
    tick();
    do_commit(bc, dn);
    n_checks++;
    if (active_regs !== exp_active() || bc !== 16) begin
      n_fail++; $display("FAIL noedge_commit: got %h busy=%0d expected %h busy=16",
                         active_regs, bc, exp_active());
    end
  endtask

  task automatic test_cancel();
    int nb; logic [7:0] st;
    bus_write(5'd2, 8'hA5);
    bus_write(5'd16, 8'h03);
    tick(); tick();
    vblank = 1'b1;
    count_busy(20, nb);
    vblank = 1'b0;
    bus_read(5'd17, st);
    n_checks++;
    if (nb !== 0 || st !== exp_status()) begin
      n_fail++; $display("FAIL cancel_both: got busy=%0d status=%h expected busy=0 status=%h",
                         nb, st, exp_status());
    end
    bus_write(5'd16, 8'h01);
    tick(); tick();
    bus_write(5'd16, 8'h02);
    tick(); tick();
    vblank = 1'b1;
    count_busy(20, nb);
    vblank = 1'b0;
    tick();
    n_checks++;
    if (nb !== 0 || active_regs !== exp_active()) begin
      n_fail++; $display("FAIL cancel_armed: got busy=%0d active=%h expected busy=0 active=%h",
                         nb, active_regs, exp_active());
    end
  endtask

  task automatic test_collision();
    logic [7:0] old_v, new_v;
    bit seen, dn; int bc;
    old_v = 8'($urandom);
    new_v = ~old_v;
    bus_write(5'd5, old_v);
    bus_write(5'd16, 8'h01);
    tick(); tick();
    pend_m = 1'b0;
    vblank = 1'b1;
    wait_busy(seen);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL collision_start: got no busy expected busy");
    end
    repeat (5) tick();
    model_commit();
    bus_write(5'd5, new_v);
    wait_done(seen);
    vblank = 1'b0;
    tick();
    n_checks++;
    if (!seen || active_regs[47:40] !== old_v) begin
      n_fail++; $display("FAIL collision_old: got %h done=%0d expected %h done=1",
                         active_regs[47:40], seen, old_v);
    end
    bus_write(5'd16, 8'h01);
    do_commit(bc, dn);
    n_checks++;
    if (active_regs[47:40] !== new_v || active_regs !== exp_active()) begin
      n_fail++; $display("FAIL collision_new: got %h expected %h", active_regs, exp_active());
    end
  endtask

  task automatic test_rearm();
    bit seen, dn; int bc; logic [7:0] st;
    bus_write(5'd16, 8'h01);
    tick(); tick();
    pend_m = 1'b0;
    vblank = 1'b1;
    wait_busy(seen);
    bus_write(5'd16, 8'h01);
    wait_done(seen);
    model_commit();
    vblank = 1'b0;
    tick();
    bus_read(5'd17, st);
    n_checks++;
    if (!seen || st !== exp_status()) begin
      n_fail++; $display("FAIL rearm_pending: got %h done=%0d expected %h done=1",
                         st, seen, exp_status());
    end
    bus_write(5'd9, 8'h3C);
    do_commit(bc, dn);
    bus_read(5'd17, st);
    n_checks++;
    if (bc !== 16 || !dn || active_regs !== exp_active() || st !== exp_status()) begin
      n_fail++; $display("FAIL rearm_second: got busy=%0d active=%h status=%h expected busy=16 active=%h status=%h",
                         bc, active_regs, st, bc, exp_active(), exp_status());
    end
  endtask

  task automatic test_random();
    int bc; bit dn; logic [7:0] st; int nw;
    for (int it = 0; it < 8; it++) begin
      nw = int'($urandom_range(1, 6));
      for (int w = 0; w < nw; w++) bus_write(5'($urandom_range(0, 15)), 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
      bus_write(5'd16, 8'h01);
      do_commit(bc, dn);
      bus_read(5'd17, st);
      n_checks++;
      if (active_regs !== exp_active() || st !== exp_status() || bc !== 16) begin
        n_fail++; $display("FAIL random_commit[%0d]: got active=%h status=%h busy=%0d expected active=%h status=%h busy=16",
                           it, active_regs, st, bc, exp_active(), exp_status());
      end
    end
  endtask

  task automatic test_wrap();
    int bc; bit dn; logic [7:0] st; int bad;
    bad = 0;
    while (commits_m % 32 != 0) begin
      bus_write(5'd16, 8'h01);
      do_commit(bc, dn);
      if (bc != 16 || !dn) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL wrap_commits: got %0d bad commits expected 0", bad);
    end
    bus_read(5'd17, st);
    n_checks++;
    if (st[4:0] !== 5'd0 || st !== exp_status()) begin
      n_fail++; $display("FAIL wrap_count: got %h expected %h", st, exp_status());
    end
  endtask

  task automatic test_irq();
    int bc; bit dn;
    bus_write(5'd16, 8'h01);
    do_commit(bc, dn);
    n_checks++;
    if (irq !== irq_m) begin
      n_fail++; $display("FAIL irq_after_done: got %b expected %b", irq, irq_m);
    end
    bus_write(5'd16, 8'h80);
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_after_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_reset_mid_copy();
    bit seen, dn; int bc; logic [7:0] st;
    for (int w = 0; w < 4; w++) bus_write(5'($urandom_range(0, 15)), 8'($urandom));
    bus_write(5'd16, 8'h01);
    tick(); tick();
    vblank = 1'b1;
    wait_busy(seen);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    bus_read(5'd17, st);
    n_checks++;
    if (busy !== 1'b0 || st !== 8'h00 || active_regs !== exp_active()) begin
      n_fail++; $display("FAIL midcopy_reset: got busy=%b status=%h active=%h expected busy=0 status=00 active=%h",
                         busy, st, active_regs, exp_active());
    end
    bus_write(5'd16, 8'h01);
    do_commit(bc, dn);
    n_checks++;
    if (active_regs !== exp_active()) begin
      n_fail++; $display("FAIL midcopy_shadow: got %h expected %h", active_regs, exp_active());
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 5'd0; writedata = 8'h00; vblank = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    test_reset();
    test_commit();
    test_no_edge();
    test_cancel();
    test_collision();
    test_rearm();
    test_random();
    test_wrap();
    test_irq();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
